// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state encoding and instruction constants for instr_ctrl_fsm
package ctrl_pkg;

  // Controller states; HALT exists only when the illegal-opcode trap is built in
  typedef enum logic [2:0] {
    ST_WAIT   = 3'd0,
    ST_DECODE = 3'd1,
    ST_WR_IMM = 3'd2,
    ST_GET_A  = 3'd3,
    ST_GET_B  = 3'd4,
    ST_EXEC   = 3'd5,
    ST_WR_REG = 3'd6
`ifdef CTRL_ILLEGAL_TRAP_EN
    , ST_HALT = 3'd7
`endif
  } state_t;

  // Major opcodes
  localparam logic [2:0] OP_MOV = 3'b110;
  localparam logic [2:0] OP_ALU = 3'b101;

  // Sub-op selectors within OP_MOV
  localparam logic [1:0] MOV_IMM = 2'b10;
  localparam logic [1:0] MOV_REG = 2'b00;

  // ALU operations within OP_ALU
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_CMP = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_MVN = 2'b11;

  // One-hot write-back source select
  localparam logic [3:0] VSEL_MDATA = 4'b0001;
  localparam logic [3:0] VSEL_IMM   = 4'b0010;
  localparam logic [3:0] VSEL_PC    = 4'b0100;
  localparam logic [3:0] VSEL_C     = 4'b1000;

endpackage

// File: rtl/instr_field_dec.sv
// rtl/instr_field_dec.sv - combinational IR field extraction and immediate sign extension
module instr_field_dec
  import ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic [W-1:0] ir_i,
  output logic [2:0]   opcode_o,
  output logic [1:0]   op_o,
  output logic [2:0]   rn_o,
  output logic [2:0]   rd_o,
  output logic [1:0]   sh_o,
  output logic [2:0]   rm_o,
  output logic [W-1:0] sximm8_o,
  output logic [W-1:0] sximm5_o
);

  // Fixed field positions of the 16-bit instruction format
  always_comb begin
    opcode_o = ir_i[15:13];
    op_o     = ir_i[12:11];
    rn_o     = ir_i[10:8];
    rd_o     = ir_i[7:5];
    sh_o     = ir_i[4:3];
    rm_o     = ir_i[2:0];
    sximm8_o = {{(W-8){ir_i[7]}}, ir_i[7:0]};
    sximm5_o = {{(W-5){ir_i[4]}}, ir_i[4:0]};
  end

endmodule

// File: rtl/instr_ctrl_fsm.sv
// rtl/instr_ctrl_fsm.sv - Moore instruction controller; CTRL_ILLEGAL_TRAP_EN enables the HALT trap
module instr_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         s,
  input  logic         load,
  input  logic [W-1:0] in,
  output logic         w,
  output logic         err,
  output logic [2:0]   readnum,
  output logic [2:0]   writenum,
  output logic [3:0]   vsel,
  output logic         loada,
  output logic         loadb,
  output logic         loadc,
  output logic         loads,
  output logic         write,
  output logic         asel,
  output logic         bsel,
  output logic [1:0]   shift,
  output logic [1:0]   ALUop,
  output logic [2:0]   opcode,
  output logic [W-1:0] sximm8,
  output logic [W-1:0] sximm5
);

  state_t         state_q, state_d;
  logic [W-1:0]   ir_q;

  logic [2:0]     f_opcode, f_rn, f_rd, f_rm;
  logic [1:0]     f_op, f_sh;
  logic           is_cmp;

  logic           w_q, write_q, loada_q, loadb_q, loadc_q, loads_q, asel_q;
  logic [2:0]     readnum_q, writenum_q;
  logic [3:0]     vsel_q;
  logic [1:0]     shift_q, aluop_q;

  instr_field_dec #(.W(W)) u_dec (
    .ir_i     (ir_q),
    .opcode_o (f_opcode),
    .op_o     (f_op),
    .rn_o     (f_rn),
    .rd_o     (f_rd),
    .sh_o     (f_sh),
    .rm_o     (f_rm),
    .sximm8_o (sximm8),
    .sximm5_o (sximm5)
  );

  assign opcode = f_opcode;
  assign is_cmp = (f_opcode == OP_ALU) && (f_op == ALU_CMP);

  // Next-state selection; IR is stable in every state that inspects it
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_WAIT:   if (s) state_d = ST_DECODE;
      ST_DECODE: begin
        if (f_opcode == OP_MOV && f_op == MOV_IMM)      state_d = ST_WR_IMM;
        else if (f_opcode == OP_MOV && f_op == MOV_REG) state_d = ST_GET_B;
        else if (f_opcode == OP_ALU && f_op == ALU_MVN) state_d = ST_GET_B;
        else if (f_opcode == OP_ALU)                    state_d = ST_GET_A;
`ifdef CTRL_ILLEGAL_TRAP_EN
        else                                            state_d = ST_HALT;
`else
        else                                            state_d = ST_WAIT;
`endif
      end
      ST_WR_IMM: state_d = ST_WAIT;
      ST_GET_A:  state_d = ST_GET_B;
      ST_GET_B:  state_d = ST_EXEC;
      ST_EXEC:   state_d = is_cmp ? ST_WAIT : ST_WR_REG;
      ST_WR_REG: state_d = ST_WAIT;
`ifdef CTRL_ILLEGAL_TRAP_EN
      ST_HALT:   state_d = ST_HALT;
`endif
      default:   state_d = ST_WAIT;
    endcase
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  logic err_q;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // State, IR and registered outputs: outputs are decoded from the state being entered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_WAIT;
      ir_q       <= '0;
      w_q        <= 1'b1;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= VSEL_C;
      readnum_q  <= '0;
      writenum_q <= '0;
      shift_q    <= '0;
      aluop_q    <= ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (state_q == ST_WAIT && load) ir_q <= in;

      w_q        <= (state_d == ST_WAIT);
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= VSEL_C;
      readnum_q  <= '0;
      writenum_q <= '0;
      shift_q    <= '0;
      aluop_q    <= ALU_ADD;
`ifdef CTRL_ILLEGAL_TRAP_EN
      err_q      <= 1'b0;
`endif
      case (state_d)
        ST_WR_IMM: begin
          writenum_q <= f_rn;
          vsel_q     <= VSEL_IMM;
          write_q    <= 1'b1;
        end
        ST_GET_A: begin
          readnum_q <= f_rn;
          loada_q   <= 1'b1;
        end
        ST_GET_B: begin
          readnum_q <= f_rm;
          loadb_q   <= 1'b1;
        end
        ST_EXEC: begin
          loadc_q <= 1'b1;
          shift_q <= f_sh;
          aluop_q <= (f_opcode == OP_ALU) ? f_op : ALU_ADD;
          asel_q  <= (f_opcode == OP_MOV);
          loads_q <= is_cmp;
        end
        ST_WR_REG: begin
          writenum_q <= f_rd;
          write_q    <= 1'b1;
        end
`ifdef CTRL_ILLEGAL_TRAP_EN
        ST_HALT: err_q <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

  assign w        = w_q;
  assign write    = write_q;
  assign loada    = loada_q;
  assign loadb    = loadb_q;
  assign loadc    = loadc_q;
  assign loads    = loads_q;
  assign asel     = asel_q;
  assign bsel     = 1'b0;
  assign vsel     = vsel_q;
  assign readnum  = readnum_q;
  assign writenum = writenum_q;
  assign shift    = shift_q;
  assign ALUop    = aluop_q;

endmodule

// File: tb/tb_instr_ctrl_fsm.sv
// tb/tb_instr_ctrl_fsm.sv - self-checking bench for instr_ctrl_fsm with a phase-list reference model
module tb_instr_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s = 1'b0;
  logic        load = 1'b0;
  logic [15:0] in_r = 16'h0;

  logic        w, err, loada, loadb, loadc, loads, write, asel, bsel;
  logic [2:0]  readnum, writenum, opcode;
  logic [3:0]  vsel;
  logic [1:0]  shift, ALUop;
  logic [15:0] sximm8, sximm5;

  int n_cmp = 0;
  int n_err = 0;

  localparam int P_IDLE = 0, P_DEC = 1, P_WRI = 2, P_GA = 3, P_GB = 4, P_EX = 5, P_WRR = 6, P_HALT = 7;

  instr_ctrl_fsm #(.W(16)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in_r),
    .w(w), .err(err), .readnum(readnum), .writenum(writenum), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(ALUop), .opcode(opcode),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [22:0] obs();
    return {w, err, write, loada, loadb, loadc, loads, asel, bsel, vsel, readnum, writenum, ALUop, shift};
  endfunction

  function automatic logic [34:0] fields_of(input logic [15:0] ir);
    return {{{8{ir[7]}}, ir[7:0]}, {{11{ir[4]}}, ir[4:0]}, ir[15:13]};
  endfunction

  // Expected outputs for one phase of an instruction: {mask, value}
  function automatic logic [45:0] expect_for(input int ph, input logic [15:0] ir);
    logic ew, eerr, ewr, ela, elb, elc, els, eas;
    logic [3:0] ev;
    logic [2:0] ern, ewn;
    logic [1:0] eal, esh;
    logic mrn, mwn, mex;
    ew = 0; eerr = 0; ewr = 0; ela = 0; elb = 0; elc = 0; els = 0; eas = 0;
    ev = 4'b1000; ern = 0; ewn = 0; eal = 0; esh = 0; mrn = 0; mwn = 0; mex = 0;
    case (ph)
      P_IDLE: ew = 1;
      P_WRI:  begin ewr = 1; ewn = ir[10:8]; mwn = 1; ev = 4'b0010; end
      P_GA:   begin ela = 1; ern = ir[10:8]; mrn = 1; end
      P_GB:   begin elb = 1; ern = ir[2:0]; mrn = 1; end
      P_EX:   begin
        elc = 1; esh = ir[4:3]; mex = 1;
        eal = (ir[15:13] == 3'b101) ? ir[12:11] : 2'b00;
        eas = (ir[15:13] == 3'b110);
        els = (ir[15:13] == 3'b101) && (ir[12:11] == 2'b01);
      end
      P_WRR:  begin ewr = 1; ewn = ir[7:5]; mwn = 1; end
      P_HALT: eerr = 1;
      default: ;
    endcase
    return {13'h1fff, {3{mrn}}, {3{mwn}}, {4{mex}},
            ew, eerr, ewr, ela, elb, elc, els, eas, 1'b0, ev, ern, ewn, eal, esh};
  endfunction

  // Issue one instruction from WAIT (called at a negedge) and check every cycle until WAIT
  task automatic run_instr(input logic [15:0] ir, input bit hold_s, input bit poke_exec);
    int plan[$];
    logic [45:0] em;
    logic [22:0] o;
    if (ir[15:11] == 5'b11010)                             plan = '{P_DEC, P_WRI};
    else if (ir[15:11] == 5'b11000)                        plan = '{P_DEC, P_GB, P_EX, P_WRR};
    else if (ir[15:13] == 3'b101 && ir[12:11] == 2'b11)    plan = '{P_DEC, P_GB, P_EX, P_WRR};
    else if (ir[15:13] == 3'b101 && ir[12:11] == 2'b01)    plan = '{P_DEC, P_GA, P_GB, P_EX};
    else if (ir[15:13] == 3'b101)                          plan = '{P_DEC, P_GA, P_GB, P_EX, P_WRR};
    else                                                   plan = '{P_DEC};
    in_r = ir; load = 1; s = 1;
    @(posedge clk); #1;
    load = 0; if (!hold_s) s = 0;
    in_r = 16'($urandom);
    foreach (plan[i]) begin
      @(negedge clk);
      load = 0;
      em = expect_for(plan[i], ir);
      o = obs();
      n_cmp++;
      if ((o & em[45:23]) !== (em[22:0] & em[45:23])) begin
        n_err++;
        $display("FAIL ctrl_outputs ir=%h step=%0d phase=%0d: got %h want %h mask %h", ir, i, plan[i], o, em[22:0], em[45:23]);
      end
      n_cmp++;
      if ({sximm8, sximm5, opcode} !== fields_of(ir)) begin
        n_err++;
        $display("FAIL ir_fields ir=%h step=%0d: got %h want %h", ir, i, {sximm8, sximm5, opcode}, fields_of(ir));
      end
      if (poke_exec && plan[i] == P_EX) begin in_r = ~ir; load = 1; end
    end
    @(negedge clk);
    load = 0;
    em = expect_for(P_IDLE, ir);
    o = obs();
    n_cmp++;
    if ((o & em[45:23]) !== (em[22:0] & em[45:23])) begin
      n_err++;
      $display("FAIL back_in_wait ir=%h after %0d cycles: got %h want %h", ir, plan.size() + 1, o, em[22:0]);
    end
    n_cmp++;
    if ({sximm8, sximm5, opcode} !== fields_of(ir)) begin
      n_err++;
      $display("FAIL ir_held ir=%h: got %h want %h", ir, {sximm8, sximm5, opcode}, fields_of(ir));
    end
  endtask

  task automatic test_reset();
    logic [45:0] em;
    reset = 1; s = 0; load = 0; in_r = 16'hD0FB;
    repeat (2) @(negedge clk);
    em = expect_for(P_IDLE, 16'h0);
    n_cmp++;
    if ((obs() & em[45:23]) !== (em[22:0] & em[45:23])) begin
      n_err++; $display("FAIL reset_outputs: got %h want %h", obs(), em[22:0]);
    end
    load = 1; s = 1;
    @(negedge clk);
    n_cmp++;
    if ({sximm8, sximm5, opcode} !== 35'h0) begin
      n_err++; $display("FAIL reset_ir_zero: got %h want 0", {sximm8, sximm5, opcode});
    end
    reset = 0;
    @(posedge clk); #1;
    load = 0; s = 0;
    @(negedge clk);
    n_cmp++;
    if (w !== 1'b0) begin n_err++; $display("FAIL first_edge_after_reset: w got %b want 0", w); end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (w !== 1'b1 || sximm8 !== 16'hFFFB) begin
      n_err++; $display("FAIL post_reset_mov: w=%b sximm8=%h want w=1 sximm8=fffb", w, sximm8);
    end
  endtask

  task automatic test_mov_imm();
    run_instr(16'hD0FB, 0, 0);
    n_cmp++;
    if (sximm8 !== 16'hFFFB) begin n_err++; $display("FAIL mov_imm_sximm8: got %h want fffb", sximm8); end
  endtask

  task automatic test_add();
    run_instr(16'hA148, 0, 0);
  endtask

  task automatic test_cmp();
    run_instr(16'hAB04, 0, 0);
  endtask

  task automatic test_illegal();
`ifdef CTRL_ILLEGAL_TRAP_EN
    in_r = 16'h0000; load = 1; s = 1;
    @(posedge clk); #1; load = 0; s = 0;
    @(negedge clk);
    n_cmp++;
    if (w !== 1'b0 || write !== 1'b0) begin n_err++; $display("FAIL illegal_decode: w=%b write=%b want 0 0", w, write); end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if (w !== 1'b0 || err !== 1'b1 || write !== 1'b0) begin
        n_err++; $display("FAIL halt_hold cycle %0d: w=%b err=%b write=%b want 0 1 0", k, w, err, write);
      end
    end
    reset = 1; #1;
    n_cmp++;
    if (err !== 1'b0 || w !== 1'b1) begin n_err++; $display("FAIL halt_reset: err=%b w=%b want 0 1", err, w); end
    @(negedge clk); reset = 0;
`else
    run_instr(16'h0000, 0, 0);
    n_cmp++;
    if (err !== 1'b0) begin n_err++; $display("FAIL err_tied: got %b want 0", err); end
`endif
  endtask

  task automatic test_reset_mid();
    in_r = 16'hA148; load = 1; s = 1;
    @(posedge clk); #1; load = 0; s = 0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (loadb !== 1'b1 || readnum !== 3'd0) begin
      n_err++; $display("FAIL reach_get_b: loadb=%b readnum=%0d want 1 0", loadb, readnum);
    end
    #2 reset = 1; #1;
    n_cmp++;
    if ({w, write, loada, loadb, loadc, loads} !== 6'b100000 || sximm8 !== 16'h0) begin
      n_err++; $display("FAIL async_reset: w/wr/la/lb/lc/ls=%b sximm8=%h want 100000 0000", {w, write, loada, loadb, loadc, loads}, sximm8);
    end
    @(negedge clk); reset = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (w !== 1'b1 || write !== 1'b0) begin
        n_err++; $display("FAIL no_wr_after_reset cycle %0d: w=%b write=%b want 1 0", k, w, write);
      end
    end
  endtask

  task automatic test_back_to_back();
    run_instr(16'hD107, 1, 0);
    run_instr(16'hB841, 0, 1);
    n_cmp++;
    if (sximm8 !== 16'h0041) begin n_err++; $display("FAIL exec_load_ignored: sximm8 got %h want 0041", sximm8); end
  endtask

  task automatic test_random();
    logic [15:0] ir;
    logic [2:0] bad [6];
    int cls, k;
    bit hold;
    bad = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    for (int n = 0; n < 40; n++) begin
      ir = 16'($urandom);
`ifdef CTRL_ILLEGAL_TRAP_EN
      cls = $urandom_range(0, 5);
`else
      cls = $urandom_range(0, 6);
`endif
      case (cls)
        0: ir[15:11] = 5'b11010;
        1: ir[15:11] = 5'b11000;
        2, 3, 4, 5: begin ir[15:13] = 3'b101; ir[12:11] = 2'(cls - 2); end
        default: begin
          k = $urandom_range(0, 7);
          if (k < 6) ir[15:13] = bad[k];
          else begin ir[15:13] = 3'b110; ir[12:11] = (k == 6) ? 2'b01 : 2'b11; end
        end
      endcase
      hold = 1'($urandom_range(0, 1));
      run_instr(ir, hold, 0);
      if (!hold) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    s = 0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_add();
    test_cmp();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
